// File: rtl/isa_pkg.sv
// rtl/isa_pkg.sv - ISA field layout, opcodes, ALU selects and decode helpers
package isa_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 3;

    localparam int OPC_MSB     = 31;
    localparam int OPC_LSB     = 24;
    localparam int DEST_LSB    = 16;
    localparam int SRC1_LSB    = 8;
    localparam int SRC2_LSB    = 0;
    localparam int REG_FIELD_W = 3;
    localparam int IMM_LSB     = 0;
    localparam int IMM_W       = 8;

    localparam logic [7:0] OPC_LOADI = 8'd0;
    localparam logic [7:0] OPC_MOV   = 8'd1;
    localparam logic [7:0] OPC_ADD   = 8'd2;
    localparam logic [7:0] OPC_SUB   = 8'd3;
    localparam logic [7:0] OPC_AND   = 8'd4;
    localparam logic [7:0] OPC_OR    = 8'd5;

    localparam logic [2:0] ALU_FWD = 3'd0;
    localparam logic [2:0] ALU_ADD = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

    function automatic logic opc_legal(input logic [7:0] opc);
        return opc <= OPC_OR;
    endfunction

    function automatic logic opc_reads_src1(input logic [7:0] opc);
        return opc inside {OPC_ADD, OPC_SUB, OPC_AND, OPC_OR};
    endfunction

    function automatic logic opc_reads_src2(input logic [7:0] opc);
        return opc inside {OPC_MOV, OPC_ADD, OPC_SUB, OPC_AND, OPC_OR};
    endfunction

endpackage

// File: rtl/scoreboard.sv
// rtl/scoreboard.sv - register busy vector with set/clear and two-source hazard query
module scoreboard #(
    parameter int ADDR_W = 3
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              set_i,
    input  logic [ADDR_W-1:0] set_addr_i,
    input  logic              clr_i,
    input  logic [ADDR_W-1:0] clr_addr_i,
    input  logic              q1_en_i,
    input  logic [ADDR_W-1:0] q1_addr_i,
    input  logic              q2_en_i,
    input  logic [ADDR_W-1:0] q2_addr_i,
    output logic              hazard_o
);

    localparam int NREG = 1 << ADDR_W;

    logic [NREG-1:0] busy_q, busy_d, set_mask, clr_mask;

    // Set is applied after clear so a same-cycle set/clear of one register leaves it busy.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_i) set_mask[set_addr_i] = 1'b1;
        if (clr_i) clr_mask[clr_addr_i] = 1'b1;
        busy_d = (busy_q & ~clr_mask) | set_mask;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) busy_q <= '0;
        else         busy_q <= busy_d;
    end

    assign hazard_o = (q1_en_i && busy_q[q1_addr_i]) || (q2_en_i && busy_q[q2_addr_i]);

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - instruction decode with scoreboard interlock and registered ALU issue
module decode_stage
    import isa_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [31:0]       INSTRUCTION,
    input  logic              IF_VALID,
    output logic              IF_READY,
    output logic [ADDR_W-1:0] OUT1ADDRESS,
    output logic [ADDR_W-1:0] OUT2ADDRESS,
    input  logic [DATA_W-1:0] REGOUT1,
    input  logic [DATA_W-1:0] REGOUT2,
    output logic              EX_VALID,
    input  logic              EX_READY,
    output logic [2:0]        EX_OP,
    output logic [DATA_W-1:0] EX_DATA1,
    output logic [DATA_W-1:0] EX_DATA2,
    output logic [ADDR_W-1:0] EX_DEST,
    output logic              EX_WRITE,
    input  logic              WB_VALID,
    input  logic [ADDR_W-1:0] WB_ADDR,
    output logic              ILLEGAL,
    output logic [7:0]        ISSUE_COUNT
);

    out_state_e        state_q, state_d;
    logic [2:0]        ex_op_q, ex_op_d;
    logic [DATA_W-1:0] ex_d1_q, ex_d1_d, ex_d2_q, ex_d2_d;
    logic [ADDR_W-1:0] ex_dest_q, ex_dest_d;
    logic              ex_write_q, ex_write_d;
    logic              illegal_q, illegal_d;
    logic [7:0]        count_q, count_d;

    logic [7:0]        opcode;
    logic [ADDR_W-1:0] dest, src1, src2;
    logic [DATA_W-1:0] imm;
    logic              legal, hazard, accept, legal_acc;
    logic [2:0]        dec_op;
    logic [DATA_W-1:0] dec_d1, dec_d2;
    logic              unused_fields;

    assign opcode = INSTRUCTION[OPC_MSB:OPC_LSB];
    assign dest   = ADDR_W'(INSTRUCTION[DEST_LSB +: REG_FIELD_W]);
    assign src1   = ADDR_W'(INSTRUCTION[SRC1_LSB +: REG_FIELD_W]);
    assign src2   = ADDR_W'(INSTRUCTION[SRC2_LSB +: REG_FIELD_W]);
    assign imm    = DATA_W'(INSTRUCTION[IMM_LSB +: IMM_W]);
    assign unused_fields = ^{INSTRUCTION[23:19], INSTRUCTION[15:11]};

    assign OUT1ADDRESS = src1;
    assign OUT2ADDRESS = src2;

    assign legal     = opc_legal(opcode);
    assign IF_READY  = (state_q == ST_EMPTY || EX_READY) && !hazard;
    assign accept    = IF_VALID && IF_READY;
    assign legal_acc = accept && legal;

    scoreboard #(.ADDR_W(ADDR_W)) u_sb (
        .clk_i      (CLK),
        .rst_ni     (RESET),
        .set_i      (legal_acc),
        .set_addr_i (dest),
        .clr_i      (WB_VALID),
        .clr_addr_i (WB_ADDR),
        .q1_en_i    (opc_reads_src1(opcode)),
        .q1_addr_i  (src1),
        .q2_en_i    (opc_reads_src2(opcode)),
        .q2_addr_i  (src2),
        .hazard_o   (hazard)
    );

    // SUB issues as an add of the negated second operand.
    always_comb begin
        dec_op = ALU_FWD;
        dec_d1 = '0;
        dec_d2 = '0;
        case (opcode)
            OPC_LOADI: dec_d2 = imm;
            OPC_MOV:   dec_d2 = REGOUT2;
            OPC_ADD:   begin dec_op = ALU_ADD; dec_d1 = REGOUT1; dec_d2 = REGOUT2;  end
            OPC_SUB:   begin dec_op = ALU_ADD; dec_d1 = REGOUT1; dec_d2 = -REGOUT2; end
            OPC_AND:   begin dec_op = ALU_AND; dec_d1 = REGOUT1; dec_d2 = REGOUT2;  end
            OPC_OR:    begin dec_op = ALU_OR;  dec_d1 = REGOUT1; dec_d2 = REGOUT2;  end
            default:   ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        ex_op_d    = ex_op_q;
        ex_d1_d    = ex_d1_q;
        ex_d2_d    = ex_d2_q;
        ex_dest_d  = ex_dest_q;
        ex_write_d = ex_write_q;
        count_d    = count_q;
        illegal_d  = accept && !legal;
        case (state_q)
            ST_EMPTY: if (legal_acc) state_d = ST_FULL;
            ST_FULL:  if (EX_READY && !legal_acc) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
        if (legal_acc) begin
            ex_op_d    = dec_op;
            ex_d1_d    = dec_d1;
            ex_d2_d    = dec_d2;
            ex_dest_d  = dest;
            ex_write_d = 1'b1;
            count_d    = count_q + 8'd1;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= ST_EMPTY;
            ex_op_q    <= '0;
            ex_d1_q    <= '0;
            ex_d2_q    <= '0;
            ex_dest_q  <= '0;
            ex_write_q <= 1'b0;
            illegal_q  <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            ex_op_q    <= ex_op_d;
            ex_d1_q    <= ex_d1_d;
            ex_d2_q    <= ex_d2_d;
            ex_dest_q  <= ex_dest_d;
            ex_write_q <= ex_write_d;
            illegal_q  <= illegal_d;
            count_q    <= count_d;
        end
    end

    assign EX_VALID    = (state_q == ST_FULL);
    assign EX_OP       = ex_op_q;
    assign EX_DATA1    = ex_d1_q;
    assign EX_DATA2    = ex_d2_q;
    assign EX_DEST     = ex_dest_q;
    assign EX_WRITE    = ex_write_q;
    assign ILLEGAL     = illegal_q;
    assign ISSUE_COUNT = count_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage
module tb_decode_stage;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic [31:0] INSTRUCTION = '0;
    logic        IF_VALID = 1'b0;
    logic        IF_READY;
    logic [2:0]  OUT1ADDRESS, OUT2ADDRESS;
    logic [7:0]  REGOUT1 = '0, REGOUT2 = '0;
    logic        EX_VALID;
    logic        EX_READY = 1'b1;
    logic [2:0]  EX_OP;
    logic [7:0]  EX_DATA1, EX_DATA2;
    logic [2:0]  EX_DEST;
    logic        EX_WRITE;
    logic        WB_VALID = 1'b0;
    logic [2:0]  WB_ADDR = '0;
    logic        ILLEGAL;
    logic [7:0]  ISSUE_COUNT;

    decode_stage #(.DATA_W(8), .ADDR_W(3)) dut (
        .CLK(CLK), .RESET(RESET), .INSTRUCTION(INSTRUCTION), .IF_VALID(IF_VALID),
        .IF_READY(IF_READY), .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS),
        .REGOUT1(REGOUT1), .REGOUT2(REGOUT2), .EX_VALID(EX_VALID), .EX_READY(EX_READY),
        .EX_OP(EX_OP), .EX_DATA1(EX_DATA1), .EX_DATA2(EX_DATA2), .EX_DEST(EX_DEST),
        .EX_WRITE(EX_WRITE), .WB_VALID(WB_VALID), .WB_ADDR(WB_ADDR), .ILLEGAL(ILLEGAL),
        .ISSUE_COUNT(ISSUE_COUNT)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk_r(input int op, input int d, input int s1, input int s2);
        logic [31:0] w;
        w = '0;
        w[31:24] = op[7:0];
        w[18:16] = d[2:0];
        w[10:8]  = s1[2:0];
        w[2:0]   = s2[2:0];
        return w;
    endfunction

    function automatic logic [31:0] mk_i(input int d, input int imm);
        logic [31:0] w;
        w = '0;
        w[18:16] = d[2:0];
        w[7:0]   = imm[7:0];
        return w;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        IF_VALID = 1'b0;
        EX_READY = 1'b1;
        WB_VALID = 1'b0;
        #2;
        RESET = 1'b1;
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [7:0]  r1, r2;
        logic [2:0]  op;
        logic [7:0]  d1, d2;
        logic [2:0]  dest;
    } vec_t;

    vec_t vt[8];

    // Reference model state, kept in plain terms of the instruction rules.
    bit m_busy[8];
    bit m_valid, m_ill;
    int m_op, m_d1, m_d2, m_dest, m_count;

    function automatic bit rd1(input int op);
        return op >= 2 && op <= 5;
    endfunction

    function automatic bit rd2(input int op);
        return op >= 1 && op <= 5;
    endfunction

    initial begin
        vt[0] = '{mk_i(2, 8'h5A),    8'h11, 8'h22, 3'd0, 8'h00, 8'h5A, 3'd2};
        vt[1] = '{mk_r(3, 1, 3, 4),  8'h10, 8'h03, 3'd1, 8'h10, 8'hFD, 3'd1};
        vt[2] = '{mk_r(2, 5, 1, 6),  8'h7F, 8'h01, 3'd1, 8'h7F, 8'h01, 3'd5};
        vt[3] = '{mk_r(4, 7, 0, 7),  8'hF0, 8'h3C, 3'd2, 8'hF0, 8'h3C, 3'd7};
        vt[4] = '{mk_r(5, 0, 2, 3),  8'hA5, 8'h0F, 3'd3, 8'hA5, 8'h0F, 3'd0};
        vt[5] = '{mk_r(1, 6, 5, 4),  8'h99, 8'h42, 3'd0, 8'h00, 8'h42, 3'd6};
        vt[6] = '{mk_r(3, 3, 1, 2),  8'h20, 8'h00, 3'd1, 8'h20, 8'h00, 3'd3};
        vt[7] = '{mk_r(3, 4, 6, 5),  8'h01, 8'h80, 3'd1, 8'h01, 8'h80, 3'd4};

        // Reset state
        do_reset();
        #1;
        check("rst_ex_valid", EX_VALID, 0);
        check("rst_ex_op", EX_OP, 0);
        check("rst_ex_data1", EX_DATA1, 0);
        check("rst_ex_data2", EX_DATA2, 0);
        check("rst_ex_dest", EX_DEST, 0);
        check("rst_ex_write", EX_WRITE, 0);
        check("rst_illegal", ILLEGAL, 0);
        check("rst_count", ISSUE_COUNT, 0);
        check("rst_if_ready", IF_READY, 1);

        // Per-opcode decode table
        for (int i = 0; i < 8; i++) begin
            do_reset();
            INSTRUCTION = vt[i].instr;
            REGOUT1 = vt[i].r1;
            REGOUT2 = vt[i].r2;
            IF_VALID = 1'b1;
            #1;
            check($sformatf("vec%0d_if_ready", i), IF_READY, 1);
            check($sformatf("vec%0d_out1addr", i), OUT1ADDRESS, vt[i].instr[10:8]);
            check($sformatf("vec%0d_out2addr", i), OUT2ADDRESS, vt[i].instr[2:0]);
            tick();
            IF_VALID = 1'b0;
            REGOUT1 = 8'hEE;
            REGOUT2 = 8'hDD;
            #1;
            check($sformatf("vec%0d_ex_valid", i), EX_VALID, 1);
            check($sformatf("vec%0d_ex_op", i), EX_OP, vt[i].op);
            if (vt[i].instr[31:24] != 8'd1)
                check($sformatf("vec%0d_ex_data1", i), EX_DATA1, vt[i].d1);
            check($sformatf("vec%0d_ex_data2", i), EX_DATA2, vt[i].d2);
            check($sformatf("vec%0d_ex_dest", i), EX_DEST, vt[i].dest);
            check($sformatf("vec%0d_ex_write", i), EX_WRITE, 1);
            check($sformatf("vec%0d_count", i), ISSUE_COUNT, 1);
        end

        // Scoreboard interlock: LOADI r2 then ADD reading r2
        do_reset();
        INSTRUCTION = mk_i(2, 8'h33);
        IF_VALID = 1'b1;
        tick();
        INSTRUCTION = mk_r(2, 4, 2, 5);
        #1;
        check("haz_stall0", IF_READY, 0);
        tick();
        check("haz_stall1", IF_READY, 0);
        WB_VALID = 1'b1;
        WB_ADDR = 3'd2;
        #1;
        check("haz_no_bypass", IF_READY, 0);
        tick();
        WB_VALID = 1'b0;
        #1;
        check("haz_release", IF_READY, 1);
        tick();
        #1;
        check("haz_add_valid", EX_VALID, 1);
        check("haz_add_dest", EX_DEST, 4);
        check("haz_add_op", EX_OP, 1);
        check("haz_count", ISSUE_COUNT, 2);
        INSTRUCTION = mk_r(1, 5, 0, 4);
        #1;
        check("haz_mov_src2", IF_READY, 0);
        INSTRUCTION = mk_i(4, 8'h01);
        WB_VALID = 1'b1;
        WB_ADDR = 3'd4;
        #1;
        check("loadi_no_haz", IF_READY, 1);
        tick();
        WB_VALID = 1'b0;
        INSTRUCTION = mk_r(1, 5, 0, 4);
        #1;
        check("set_wins", IF_READY, 0);
        IF_VALID = 1'b0;

        // Output hold under back-pressure
        do_reset();
        EX_READY = 1'b0;
        INSTRUCTION = mk_i(1, 8'hC3);
        IF_VALID = 1'b1;
        tick();
        INSTRUCTION = mk_i(5, 8'h77);
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("hold%0d_valid", k), EX_VALID, 1);
            check($sformatf("hold%0d_data2", k), EX_DATA2, 8'hC3);
            check($sformatf("hold%0d_dest", k), EX_DEST, 1);
            check($sformatf("hold%0d_if_ready", k), IF_READY, 0);
            tick();
        end
        EX_READY = 1'b1;
        #1;
        check("hold_release_ready", IF_READY, 1);
        tick();
        IF_VALID = 1'b0;
        #1;
        check("hold_next_valid", EX_VALID, 1);
        check("hold_next_data2", EX_DATA2, 8'h77);
        check("hold_next_dest", EX_DEST, 5);
        check("hold_next_count", ISSUE_COUNT, 2);
        tick();
        check("drain_empty", EX_VALID, 0);

        // Illegal opcode
        do_reset();
        INSTRUCTION = 32'h0903_0000;
        IF_VALID = 1'b1;
        #1;
        check("ill_ready", IF_READY, 1);
        tick();
        IF_VALID = 1'b0;
        #1;
        check("ill_pulse", ILLEGAL, 1);
        check("ill_ex_valid", EX_VALID, 0);
        check("ill_count", ISSUE_COUNT, 0);
        tick();
        check("ill_pulse_end", ILLEGAL, 0);
        INSTRUCTION = mk_r(1, 0, 0, 3);
        IF_VALID = 1'b1;
        #1;
        check("ill_no_busy", IF_READY, 1);
        IF_VALID = 1'b0;

        // Issue-count wrap and asynchronous reset mid-stream
        do_reset();
        IF_VALID = 1'b1;
        for (int k = 0; k < 256; k++) begin
            INSTRUCTION = mk_i(k % 8, k);
            WB_VALID = (k > 0);
            WB_ADDR = 3'((k + 7) % 8);
            if (k == 255) begin
                #1;
                check("wrap_pre", ISSUE_COUNT, 8'hFF);
            end
            tick();
        end
        IF_VALID = 1'b0;
        WB_VALID = 1'b0;
        #1;
        check("wrap_zero", ISSUE_COUNT, 0);
        INSTRUCTION = mk_i(3, 8'hEE);
        IF_VALID = 1'b1;
        tick();
        tick();
        #1;
        RESET = 1'b0;
        #1;
        check("arst_ex_valid", EX_VALID, 0);
        check("arst_ex_op", EX_OP, 0);
        check("arst_ex_data", {EX_DATA1, EX_DATA2}, 0);
        check("arst_ex_dest", EX_DEST, 0);
        check("arst_ex_write", EX_WRITE, 0);
        check("arst_count", ISSUE_COUNT, 0);
        check("arst_illegal", ILLEGAL, 0);
        #1;
        RESET = 1'b1;
        tick();
        #1;
        check("post_rst_valid", EX_VALID, 1);
        check("post_rst_data2", EX_DATA2, 8'hEE);
        check("post_rst_count", ISSUE_COUNT, 1);
        IF_VALID = 1'b0;

        // Randomised traffic against the reference model
        do_reset();
        m_valid = 0; m_ill = 0; m_count = 0;
        m_op = 0; m_d1 = 0; m_d2 = 0; m_dest = 0;
        foreach (m_busy[j]) m_busy[j] = 0;
        #1;
        for (int c = 0; c < 3000; c++) begin
            int sel, opc, dst, s1, s2, r1, r2, wa;
            bit ivld, erdy, wbv, haz, rdy, acc, leg;
            logic [31:0] w;
            sel = $urandom_range(0, 8);
            opc = (sel <= 7) ? sel : $urandom_range(8, 255);
            w = $urandom;
            w[31:24] = opc[7:0];
            dst = w[18:16];
            s1 = w[10:8];
            s2 = w[2:0];
            r1 = $urandom_range(0, 255);
            r2 = $urandom_range(0, 255);
            ivld = ($urandom_range(0, 3) != 0);
            erdy = ($urandom_range(0, 2) != 0);
            wbv = $urandom_range(0, 1);
            wa = $urandom_range(0, 7);
            INSTRUCTION = w;
            REGOUT1 = r1[7:0];
            REGOUT2 = r2[7:0];
            IF_VALID = ivld;
            EX_READY = erdy;
            WB_VALID = wbv;
            WB_ADDR = wa[2:0];
            #1;
            haz = (rd1(opc) && m_busy[s1]) || (rd2(opc) && m_busy[s2]);
            rdy = (!m_valid || erdy) && !haz;
            check("rnd_if_ready", IF_READY, rdy);
            check("rnd_out1", OUT1ADDRESS, s1);
            check("rnd_out2", OUT2ADDRESS, s2);
            check("rnd_ex_valid", EX_VALID, m_valid);
            check("rnd_illegal", ILLEGAL, m_ill);
            check("rnd_count", ISSUE_COUNT, m_count);
            if (m_valid) begin
                check("rnd_ex_op", EX_OP, m_op);
                check("rnd_ex_data1", EX_DATA1, m_d1);
                check("rnd_ex_data2", EX_DATA2, m_d2);
                check("rnd_ex_dest", EX_DEST, m_dest);
                check("rnd_ex_write", EX_WRITE, 1);
            end
            acc = ivld && rdy;
            leg = (opc <= 5);
            m_ill = acc && !leg;
            if (wbv) m_busy[wa] = 0;
            if (acc && leg) begin
                m_busy[dst] = 1;
                m_valid = 1;
                m_dest = dst;
                m_count = (m_count + 1) % 256;
                case (opc)
                    0: begin m_op = 0; m_d1 = 0;  m_d2 = w[7:0]; end
                    1: begin m_op = 0; m_d1 = 0;  m_d2 = r2; end
                    2: begin m_op = 1; m_d1 = r1; m_d2 = r2; end
                    3: begin m_op = 1; m_d1 = r1; m_d2 = (256 - r2) % 256; end
                    4: begin m_op = 2; m_d1 = r1; m_d2 = r2; end
                    default: begin m_op = 3; m_d1 = r1; m_d2 = r2; end
                endcase
            end else if (erdy) begin
                m_valid = 0;
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter DATA_W, default 8, register and operand data width.
REQ-002 Parameter ADDR_W, default 3, register address width; 8 registers.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 CLK  input  1  clock; all state updates on rising edge.
REQ-005 RESET  input  1  asynchronous, active-low reset.
REQ-006 INSTRUCTION  input  32  fetched word: [31:24] opcode, [18:16] dest, [10:8] src1, [2:0] src2, [7:0] immediate.
REQ-007 IF_VALID  input  1  INSTRUCTION valid; IF_READY  output  1  decode accepts this cycle.
REQ-008 OUT1ADDRESS, OUT2ADDRESS  output  ADDR_W  register file read addresses, combinationally equal to INSTRUCTION src1/src2.
REQ-009 REGOUT1, REGOUT2  input  DATA_W  register file read data, sampled at the accepting edge.
REQ-010 EX_VALID  output  1; EX_READY  input  1; valid/ready handshake to ALU stage.
REQ-011 EX_OP  output  3  ALU select: 0 forward, 1 add, 2 and, 3 or.
REQ-012 EX_DATA1, EX_DATA2  output  DATA_W  operands; EX_DEST  output  ADDR_W; EX_WRITE  output  1  result must be written back.
REQ-013 WB_VALID  input  1; WB_ADDR  input  ADDR_W; writeback of register WB_ADDR completes this cycle.
REQ-014 ILLEGAL  output  1  one-cycle pulse on unknown opcode; ISSUE_COUNT  output  8  issued-instruction count.

Function
REQ-015 Opcodes: 0 LOADI, 1 MOV, 2 ADD, 3 SUB, 4 AND, 5 OR; all others illegal.
REQ-016 Handshake: transfer occurs when IF_VALID && IF_READY; IF_READY = (!EX_VALID || EX_READY) && !hazard.
REQ-017 Output register states: EMPTY (EX_VALID=0) and FULL (EX_VALID=1); EMPTY->FULL on legal accept; FULL->EMPTY on EX_READY without accept; FULL->FULL on EX_READY with accept.
REQ-018 While FULL and EX_READY=0, all EX_* outputs hold stable.
REQ-019 Latency: accepted instruction appears on EX_* one cycle after the accepting edge.
REQ-020 LOADI: EX_OP=0, EX_DATA2=immediate, EX_DATA1=0; MOV: EX_OP=0, EX_DATA2=REGOUT2.
REQ-021 ADD/AND/OR: EX_DATA1=REGOUT1, EX_DATA2=REGOUT2, EX_OP=1/2/3.
REQ-022 SUB: EX_OP=1, EX_DATA2 = two's complement of REGOUT2 modulo 2^DATA_W (0x00->0x00, 0x80->0x80).
REQ-023 All legal opcodes set EX_WRITE=1 and EX_DEST=dest.
REQ-024 Scoreboard: 8-bit busy vector; bit dest set on legal accept, bit WB_ADDR cleared on WB_VALID.
REQ-025 Same-cycle set and clear of the same bit: set wins.
REQ-026 Hazard: any source read by the opcode (src1 for ADD/SUB/AND/OR; src2 for MOV/ADD/SUB/AND/OR) has busy bit set; no bypass, clear visible next cycle.
REQ-027 LOADI never hazards.
REQ-028 Illegal opcode: accepted when ready and no hazard; ILLEGAL pulses; no scoreboard change; EX_VALID not raised; ISSUE_COUNT unchanged.
REQ-029 ISSUE_COUNT increments by 1 per legal accept, wraps 0xFF->0x00.

Reset
REQ-030 RESET low asynchronously clears EX_VALID, EX_OP, EX_DATA1, EX_DATA2, EX_DEST, EX_WRITE, ILLEGAL, ISSUE_COUNT and the busy vector to 0.
REQ-031 Reset mid-operation discards any held instruction; first accept is possible on the first edge after RESET rises.

Structure
REQ-032 Package isa_pkg holds opcode constants, field bit positions, ALU select encodings, and DATA_W/ADDR_W defaults.
REQ-033 Scoreboard is a sub-module named scoreboard (set, clear, two-source hazard query).

Verification
REQ-034 Reset then LOADI dest=2 imm=0x5A -> next cycle EX_VALID=1, EX_OP=0, EX_DATA2=0x5A, EX_DEST=2, busy[2]=1.
REQ-035 SUB dest=1 src1=3 src2=4, REGOUT1=0x10, REGOUT2=0x03 -> EX_OP=1, EX_DATA1=0x10, EX_DATA2=0xFD.
REQ-036 LOADI dest=2 then ADD src1=2 -> IF_READY=0 until WB_VALID with WB_ADDR=2; ADD accepted the cycle after.
REQ-037 Hold EX_READY=0 with EX_VALID=1 for 5 cycles -> EX_* unchanged, IF_READY=0; EX_READY=1 -> next transfer proceeds.
REQ-038 Opcode 0x09 -> ILLEGAL one-cycle pulse, EX_VALID stays 0, ISSUE_COUNT unchanged.
REQ-039 Issue 256 LOADIs with WB clearing each -> ISSUE_COUNT wraps to 0x00; RESET asserted mid-stream -> all outputs 0 immediately.
